// File: rtl/p1_pool_pkg.sv
// Shared types and constants for the pooling-1 read engine.
package p1_pool_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned IN_DIM     = 24;
   localparam int unsigned POOL_DIM   = IN_DIM / 2;
   localparam int unsigned HALF_PAIRS = POOL_DIM * POOL_DIM / 2;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      DRAIN,
      HOLD,
      DONE
   } p1r_state_t;

   // Slot k[2] picks the lower half of the map, k[1] the window row, k[0] the window column.
   function automatic logic [9:0] rd_addr_f(
      input int unsigned in_dim,
      input logic [2:0]  pr,
      input logic [3:0]  pc,
      input logic [2:0]  k
   );
      int unsigned row;
      int unsigned col;
      row = 2 * (32'(pr) + (in_dim / 4) * 32'(k[2])) + 32'(k[1]);
      col = 2 * 32'(pc) + 32'(k[0]);
      return 10'(row * in_dim + col);
   endfunction

endpackage

// File: rtl/p1_max_acc.sv
// Signed load/compare max accumulator; P1_POOL_RELU_EN clamps negative results to zero.
module p1_max_acc #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              cmp_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] acc_o
);

   logic signed [DATA_W-1:0] acc_q, acc_d;
   logic signed [DATA_W-1:0] din_s;

   assign din_s = signed'(din_i);

   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = din_s;
      end else if (cmp_i && (din_s > acc_q)) begin
         acc_d = din_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

`ifdef P1_POOL_RELU_EN
   assign acc_o = acc_q[DATA_W-1] ? '0 : acc_q;
`else
   assign acc_o = acc_q;
`endif

endmodule

// File: rtl/p1_pool_read.sv
// Pooling-1 read address generator and 2x2 max-pool engine producing (p, p+72) pairs.
// Optional macro P1_POOL_RELU_EN (in p1_max_acc) clamps outputs at zero.
module p1_pool_read #(
   parameter int unsigned DATA_W = p1_pool_pkg::DATA_W,
   parameter int unsigned IN_DIM = p1_pool_pkg::IN_DIM,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              rd_en,
   output logic [9:0]        rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done
);

   import p1_pool_pkg::*;

   localparam int unsigned PSIDE   = IN_DIM / 2;
   localparam logic [2:0]  PR_LAST = 3'(PSIDE / 2 - 1);
   localparam logic [3:0]  PC_LAST = 4'(PSIDE - 1);

   p1r_state_t state_q, state_d;

   logic [2:0] pr_q, pr_d;
   logic [3:0] pc_q, pc_d;
   logic [2:0] k_q, k_d;
   logic       rd_en_q, rd_en_d;
   logic [9:0] rd_addr_q, rd_addr_d;
   logic [2:0] slot_q, slot_d;

   logic [RD_LAT-1:0] tag_v_q;
   logic [2:0]        tag_s_q [RD_LAT];

   logic       issue, accept, last_pair, inflight;
   logic       ret_v;
   logic [2:0] ret_slot;
   logic       load0, cmp0, load1, cmp1;

   assign issue     = (state_q == READ) && enable;
   assign accept    = (state_q == HOLD) && out_ready;
   assign last_pair = (pr_q == PR_LAST) && (pc_q == PC_LAST);
   assign ret_v     = tag_v_q[RD_LAT-1];
   assign ret_slot  = tag_s_q[RD_LAT-1];

   // Outstanding reads excluding the one landing this cycle.
   always_comb begin
      inflight = rd_en_q;
      for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
         inflight = inflight | tag_v_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = READ;
         READ:    if (issue && (k_q == 3'd7)) state_d = DRAIN;
         DRAIN:   if (!inflight) state_d = HOLD;
         HOLD:    if (out_ready) state_d = last_pair ? DONE : READ;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state_q == HOLD);
      done      = (state_q == DONE);
   end

   always_comb begin
      pr_d      = pr_q;
      pc_d      = pc_q;
      k_d       = k_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      slot_d    = slot_q;
      if (issue) begin
         rd_en_d   = 1'b1;
         rd_addr_d = rd_addr_f(IN_DIM, pr_q, pc_q, k_q);
         slot_d    = k_q;
         k_d       = k_q + 3'd1;
      end
      if (accept) begin
         if (pc_q == PC_LAST) begin
            pc_d = '0;
            pr_d = last_pair ? '0 : pr_q + 3'd1;
         end else begin
            pc_d = pc_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pr_q      <= '0;
         pc_q      <= '0;
         k_q       <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         slot_q    <= '0;
         tag_v_q   <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            tag_s_q[i] <= '0;
         end
      end else begin
         pr_q       <= pr_d;
         pc_q       <= pc_d;
         k_q        <= k_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         slot_q     <= slot_d;
         tag_v_q[0] <= rd_en_q;
         tag_s_q[0] <= slot_q;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
            tag_s_q[i] <= tag_s_q[i-1];
         end
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;

   assign load0 = ret_v && !ret_slot[2] && (ret_slot[1:0] == 2'd0);
   assign cmp0  = ret_v && !ret_slot[2] && (ret_slot[1:0] != 2'd0);
   assign load1 = ret_v &&  ret_slot[2] && (ret_slot[1:0] == 2'd0);
   assign cmp1  = ret_v &&  ret_slot[2] && (ret_slot[1:0] != 2'd0);

   p1_max_acc #(.DATA_W(DATA_W)) u_acc0 (
      .clk    (clk),
      .rst_n  (reset),
      .load_i (load0),
      .cmp_i  (cmp0),
      .din_i  (rd_data),
      .acc_o  (out0)
   );

   p1_max_acc #(.DATA_W(DATA_W)) u_acc1 (
      .clk    (clk),
      .rst_n  (reset),
      .load_i (load1),
      .cmp_i  (cmp1),
      .din_i  (rd_data),
      .acc_o  (out1)
   );

endmodule
